// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared AXI read-channel widths, arbiter state encoding, master
//            tag constants and AR/R field bundles for rom_read_arbiter.
// Contents : AXI_*_BITS widths, arb_state_e, TAG_M0/TAG_M1,
//            ar_fields_t, r_fields_t
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Tag placed in the upper slave-side ID bits to mark the issuing master.
  localparam logic TAG_M0 = 1'b0;
  localparam logic TAG_M1 = 1'b1;

  typedef struct packed {
    logic [AXI_ADDR_BITS-1:0] addr;
    logic [AXI_LEN_BITS-1:0]  len;
    logic [AXI_SIZE_BITS-1:0] size;
    logic [1:0]               burst;
  } ar_fields_t;

  typedef struct packed {
    logic [AXI_DATA_BITS-1:0] data;
    logic [1:0]               resp;
    logic                     last;
  } r_fields_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin picker. A lone request wins outright; when
//            both request, the input named by prio_i wins.
// Ports    : req_i [1:0] in  - request vector (bit x = master x)
//            prio_i      in  - preferred master on contention
//            gnt_o       out - index of the selected master
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       gnt_o
);

  // With no request the output is don't-care; req_i[1] gives 0 there.
  assign gnt_o = (req_i == 2'b11) ? prio_i : req_i[1];

endmodule
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_read_arbiter
// Purpose  : Shares one ROM AXI read slave between M0 (instruction fetch) and
//            M1 (data read). One outstanding transaction; grant held for the
//            whole burst, round-robin priority updated at burst completion.
// Ports    : ACLK, ARESETn (async, active-low)
//            AR*_M0/M1 in, ARREADY_M0/M1 out   - master address channels
//            R*_M0/M1 out, RREADY_M0/M1 in     - master data channels
//            AR*_S out, ARREADY_S in           - slave address channel
//            R*_S in, RREADY_S out             - slave data channel
// Revision : 1.0 - initial release
// ============================================================================
module rom_read_arbiter
  import axi_pkg::*;
#(
  parameter int ID_W  = AXI_ID_BITS,
  parameter int IDS_W = AXI_IDS_BITS
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  // M0 read address
  input  logic [ID_W-1:0]          ARID_M0,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [1:0]               ARBURST_M0,
  input  logic                     ARVALID_M0,
  output logic                     ARREADY_M0,
  // M0 read data
  output logic [ID_W-1:0]          RID_M0,
  output logic [AXI_DATA_BITS-1:0] RDATA_M0,
  output logic [1:0]               RRESP_M0,
  output logic                     RLAST_M0,
  output logic                     RVALID_M0,
  input  logic                     RREADY_M0,
  // M1 read address
  input  logic [ID_W-1:0]          ARID_M1,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]               ARBURST_M1,
  input  logic                     ARVALID_M1,
  output logic                     ARREADY_M1,
  // M1 read data
  output logic [ID_W-1:0]          RID_M1,
  output logic [AXI_DATA_BITS-1:0] RDATA_M1,
  output logic [1:0]               RRESP_M1,
  output logic                     RLAST_M1,
  output logic                     RVALID_M1,
  input  logic                     RREADY_M1,
  // Slave read address
  output logic [IDS_W-1:0]         ARID_S,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]               ARBURST_S,
  output logic                     ARVALID_S,
  input  logic                     ARREADY_S,
  // Slave read data
  input  logic [IDS_W-1:0]         RID_S,
  input  logic [AXI_DATA_BITS-1:0] RDATA_S,
  input  logic [1:0]               RRESP_S,
  input  logic                     RLAST_S,
  input  logic                     RVALID_S,
  output logic                     RREADY_S
);

  arb_state_e state_q;
  logic       gnt_q;
  logic       prio_q;

  logic             w_pick;
  logic [1:0]       w_req;
  ar_fields_t       w_ar_sel;
  r_fields_t        w_r;
  logic [ID_W-1:0]  w_arid_sel;
  logic [IDS_W-ID_W-1:0] w_tag;
  logic             w_rready_sel;
  logic             w_unused_rid_tag;

  assign w_req = {ARVALID_M1, ARVALID_M0};

  rr_arb2 u_rr_arb2 (
    .req_i  (w_req),
    .prio_i (prio_q),
    .gnt_o  (w_pick)
  );

  // Granted master's AR fields and R-ready.
  assign w_ar_sel   = gnt_q ? ar_fields_t'{ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1}
                            : ar_fields_t'{ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
  assign w_arid_sel   = gnt_q ? ARID_M1 : ARID_M0;
  assign w_rready_sel = gnt_q ? RREADY_M1 : RREADY_M0;
  assign w_r          = r_fields_t'{RDATA_S, RRESP_S, RLAST_S};

  // Slave-side tag bits are returned by the ROM but routing follows gnt_q,
  // so they are intentionally not consumed.
  assign w_unused_rid_tag = ^RID_S[IDS_W-1:ID_W];

  always_comb begin
    w_tag    = '0;
    w_tag[0] = gnt_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_q   <= TAG_M0;
      prio_q  <= TAG_M0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|w_req) begin
            gnt_q   <= w_pick;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          // ARVALID_S is constant 1 in this state, so ARREADY_S alone completes AR.
          if (ARREADY_S) state_q <= DATA;
        end
        DATA: begin
          if (RVALID_S && w_rready_sel && RLAST_S) begin
            state_q <= IDLE;
            prio_q  <= ~gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All channel outputs are gated by state so that an asynchronous reset
  // forces them to zero immediately.
  always_comb begin
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RREADY_S   = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;

    if (state_q == ADDR) begin
      ARVALID_S  = 1'b1;
      ARID_S     = {w_tag, w_arid_sel};
      ARADDR_S   = w_ar_sel.addr;
      ARLEN_S    = w_ar_sel.len;
      ARSIZE_S   = w_ar_sel.size;
      ARBURST_S  = w_ar_sel.burst;
      ARREADY_M0 = (gnt_q == TAG_M0) && ARREADY_S;
      ARREADY_M1 = (gnt_q == TAG_M1) && ARREADY_S;
    end

    if (state_q == DATA) begin
      RREADY_S = w_rready_sel;
      if (gnt_q == TAG_M0) begin
        RID_M0    = RID_S[ID_W-1:0];
        RDATA_M0  = w_r.data;
        RRESP_M0  = w_r.resp;
        RLAST_M0  = w_r.last;
        RVALID_M0 = RVALID_S;
      end else begin
        RID_M1    = RID_S[ID_W-1:0];
        RDATA_M1  = w_r.data;
        RRESP_M1  = w_r.resp;
        RLAST_M1  = w_r.last;
        RVALID_M1 = RVALID_S;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_read_arbiter
// Purpose  : Self-checking bench for rom_read_arbiter: transaction-level
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_read_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S, RID_S;
  logic [31:0] ARADDR_S, RDATA_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S, RRESP_S;
  logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

  rom_read_arbiter #(.ID_W(4), .IDS_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Output bundles for compact comparison.
  logic [49:0] ar_bus;
  logic [39:0] r0_bus, r1_bus;
  logic [2:0]  ctl_bus;
  assign ar_bus  = {ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S};
  assign r0_bus  = {RVALID_M0, RID_M0, RDATA_M0, RRESP_M0, RLAST_M0};
  assign r1_bus  = {RVALID_M1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1};
  assign ctl_bus = {ARREADY_M0, ARREADY_M1, RREADY_S};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  // busy: a transaction owns the slave; addr_sent: its AR beat was accepted.
  bit m_busy, m_addr_sent;
  int m_owner, m_prio;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_busy = 0; m_addr_sent = 0; m_owner = 0; m_prio = 0;
    end else if (!m_busy) begin
      if (ARVALID_M0 || ARVALID_M1) begin
        m_owner = (ARVALID_M0 && ARVALID_M1) ? m_prio : (ARVALID_M1 ? 1 : 0);
        m_busy = 1; m_addr_sent = 0;
      end
    end else if (!m_addr_sent) begin
      if (ARREADY_S) m_addr_sent = 1;
    end else if (RVALID_S && RLAST_S && (m_owner == 0 ? RREADY_M0 : RREADY_M1)) begin
      m_busy = 0;
      m_prio = 1 - m_owner;
    end
  end

  logic [36:0] rx0[$], rx1[$];
  int acc0, acc1;

  // Compare process: mid-cycle, all inputs stable.
  always @(negedge ACLK) begin
    logic [49:0] e_ar;
    logic [39:0] e_r0, e_r1, beat;
    logic [2:0]  e_ctl;
    e_ar = '0; e_r0 = '0; e_r1 = '0; e_ctl = '0;
    beat = {RVALID_S, RID_S[3:0], RDATA_S, RRESP_S, RLAST_S};
    if (m_busy && !m_addr_sent) begin
      if (m_owner == 0) begin
        e_ar = {1'b1, 4'h0, ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
        e_ctl[2] = ARREADY_S;
      end else begin
        e_ar = {1'b1, 4'h1, ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};
        e_ctl[1] = ARREADY_S;
      end
    end else if (m_busy) begin
      if (m_owner == 0) begin e_r0 = beat; e_ctl[0] = RREADY_M0; end
      else              begin e_r1 = beat; e_ctl[0] = RREADY_M1; end
    end
    chk("ar_s", 64'(ar_bus), 64'(e_ar));
    chk("r_m0", 64'(r0_bus), 64'(e_r0));
    chk("r_m1", 64'(r1_bus), 64'(e_r1));
    chk("ready", 64'(ctl_bus), 64'(e_ctl));
    if (RVALID_M0 && RREADY_M0) rx0.push_back({RID_M0, RDATA_M0, RLAST_M0});
    if (RVALID_M1 && RREADY_M1) rx1.push_back({RID_M1, RDATA_M1, RLAST_M1});
    if (ARREADY_M0) acc0++;
    if (ARREADY_M1) acc1++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] bdata(input logic [7:0] id, input int b);
    return 32'hC0DE_0000 | {16'h0, id, 8'h0} | 32'(b);
  endfunction

  task automatic req(input int m, input logic [3:0] id, input logic [31:0] addr,
                     input logic [3:0] len);
    if (m == 0) begin
      ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len; ARSIZE_M0 = 3'd2;
      ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b1;
    end else begin
      ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len; ARSIZE_M1 = 3'd2;
      ARBURST_M1 = 2'b01; ARVALID_M1 = 1'b1;
    end
  endtask

  // ROM slave: accept one AR after dly cycles, return len+1 beats.
  task automatic serve(input int dly, input int stall_beat, input int stall_cyc,
                       input bit keep, input int abort_beat,
                       output logic [7:0] id_o, output int wait_o);
    int n;
    int len;
    n = 0;
    id_o = '0;
    while (!ARVALID_S && n < 20) begin tick(); n++; end
    wait_o = n;
    if (!ARVALID_S) begin
      chk("ar_timeout", 64'(0), 64'(1));
      return;
    end
    id_o = ARID_S;
    len  = int'(ARLEN_S);
    repeat (dly) tick();
    ARREADY_S = 1'b1;
    tick();
    ARREADY_S = 1'b0;
    if (!keep) begin
      if (id_o[4]) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
    end
    for (int b = 0; b <= len; b++) begin
      RVALID_S = 1'b1; RID_S = id_o; RDATA_S = bdata(id_o, b);
      RRESP_S = 2'b00; RLAST_S = (b == len);
      if (b == abort_beat) begin
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_async_ar", 64'(ar_bus), 64'(0));
        chk("rst_async_r0", 64'(r0_bus), 64'(0));
        chk("rst_async_ready", 64'(ctl_bus), 64'(0));
        RVALID_S = 1'b0; RLAST_S = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        tick(); tick();
        ARESETn = 1'b1;
        return;
      end
      if (b == stall_beat) begin
        if (id_o[4]) RREADY_M1 = 1'b0; else RREADY_M0 = 1'b0;
        repeat (stall_cyc) tick();
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
      end
      tick();
    end
    RVALID_S = 1'b0; RLAST_S = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] id;
    int w;
    ARESETn = 1'b0;
    ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 0;
    ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 0;
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    ARREADY_S = 0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 0; RVALID_S = 0;
    repeat (3) tick();
    chk("reset_ar", 64'(ar_bus), 64'(0));
    chk("reset_r", 64'({r0_bus, r1_bus} != 0), 64'(0));
    chk("reset_ready", 64'(ctl_bus), 64'(0));
    ARESETn = 1'b1;
    tick();

    // Both request out of reset: M0 first, then M1.
    req(0, 4'h1, 32'h0000_0000, 4'd1);
    req(1, 4'h2, 32'h0000_0200, 4'd1);
    serve(0, -1, 0, 0, -1, id, w);
    chk("both_first_tag", 64'(id), 64'(8'h01));
    serve(0, -1, 0, 0, -1, id, w);
    chk("both_second_tag", 64'(id), 64'(8'h12));

    // Strict alternation with both held high.
    req(0, 4'h3, 32'h0000_0040, 4'd0);
    req(1, 4'h4, 32'h0000_0240, 4'd0);
    for (int i = 0; i < 4; i++) begin
      serve(0, -1, 0, 1, -1, id, w);
      chk("alt_tag", 64'(id[4]), 64'(i % 2));
    end
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    repeat (2) tick();

    // M0 alone, 4 beats.
    rx0.delete(); rx1.delete();
    req(0, 4'hA, 32'h0000_0100, 4'd3);
    serve(0, -1, 0, 0, -1, id, w);
    chk("m0_grant_latency", 64'(w), 64'(1));
    chk("m0_arid", 64'(id), 64'(8'h0A));
    chk("m0_beats", 64'(rx0.size()), 64'(4));
    chk("m1_beats_none", 64'(rx1.size()), 64'(0));
    if (rx0.size() == 4) begin
      chk("m0_beat0", 64'(rx0[0]), 64'({4'hA, 32'hC0DE_0A00, 1'b0}));
      chk("m0_last", 64'(rx0[3]), 64'({4'hA, 32'hC0DE_0A03, 1'b1}));
    end
    tick();

    // M1 alone, single beat.
    rx0.delete(); rx1.delete(); acc0 = 0;
    req(1, 4'h5, 32'h0000_0500, 4'd0);
    serve(0, -1, 0, 0, -1, id, w);
    chk("m1_arid", 64'(id), 64'(8'h15));
    chk("m1_beats", 64'(rx1.size()), 64'(1));
    if (rx1.size() == 1) chk("m1_beat", 64'(rx1[0]), 64'({4'h5, 32'hC0DE_1500, 1'b1}));
    chk("m1_no_m0_arready", 64'(acc0), 64'(0));
    tick();

    // R backpressure on M0 mid-burst.
    rx0.delete(); rx1.delete();
    req(0, 4'h3, 32'h0000_0300, 4'd3);
    serve(0, 1, 3, 0, -1, id, w);
    chk("bp_beats", 64'(rx0.size()), 64'(4));
    for (int k = 0; k < rx0.size(); k++)
      chk("bp_beat", 64'(rx0[k]), 64'({4'h3, bdata(8'h03, k), k == 3}));
    tick();

    // Slave AR acceptance delayed 5 cycles.
    acc0 = 0; acc1 = 0;
    req(0, 4'h7, 32'h0000_0700, 4'd1);
    serve(5, -1, 0, 0, -1, id, w);
    chk("ardly_m0_pulses", 64'(acc0), 64'(1));
    chk("ardly_m1_pulses", 64'(acc1), 64'(0));
    tick();

    // Reset during beat 2 of an M0 burst (priority is M1 at this point).
    rx0.delete(); rx1.delete();
    req(0, 4'h9, 32'h0000_0900, 4'd3);
    serve(0, -1, 0, 0, 1, id, w);
    tick();
    req(0, 4'h6, 32'h0000_0600, 4'd0);
    req(1, 4'h5, 32'h0000_0500, 4'd1);
    serve(0, -1, 0, 0, -1, id, w);
    chk("post_rst_prio_m0", 64'(id), 64'(8'h06));
    rx1.delete();
    serve(0, -1, 0, 0, -1, id, w);
    chk("post_rst_m1_arid", 64'(id), 64'(8'h15));
    chk("post_rst_m1_beats", 64'(rx1.size()), 64'(2));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

AXI read-channel arbiter that shares the single ROM read slave between two read masters: M0, instruction fetch, and M1, data-side read. It grants one master at a time and forwards that master's AR beat to the ROM wrapper. It then routes the R burst back to the granted master and releases the grant after the last beat. It sits between the CPU's two read ports and the ROM wrapper's slave port, and allows exactly one outstanding transaction.

## Interface
Parameters:
- ID_W, `AXI_ID_BITS (4): master-side ID width.
- IDS_W, `AXI_IDS_BITS (8): slave-side ID width. Bits [IDS_W-1:ID_W] carry the master tag; bits [ID_W-1:0] carry the original ID.

Ports. Each "_Mx" line means one port per master, x = 0 and 1.
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous, active-low reset.
- ARID_Mx  in  ID_W  read address ID.
- ARADDR_Mx  in  `AXI_ADDR_BITS (32)  read address.
- ARLEN_Mx  in  `AXI_LEN_BITS (4)  burst length.
- ARSIZE_Mx  in  `AXI_SIZE_BITS (3)  beat size.
- ARBURST_Mx  in  2  burst type.
- ARVALID_Mx  in  1  address valid.
- ARREADY_Mx  out  1  address ready.
- RID_Mx  out  ID_W  = RID_S[ID_W-1:0].
- RDATA_Mx  out  `AXI_DATA_BITS (32)  read data.
- RRESP_Mx  out  2  read response.
- RLAST_Mx  out  1  last beat.
- RVALID_Mx  out  1  read valid.
- RREADY_Mx  in  1  read ready.
- ARID_S  out  IDS_W  {tag, ARID_Mx}; tag = 0 for M0, 1 for M1.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as above  copies of the granted master's fields.
- ARVALID_S  out  1  address valid to ROM.
- ARREADY_S  in  1  address ready from ROM.
- RID_S  in  IDS_W  read ID from ROM.
- RDATA_S  in  32  read data from ROM.
- RRESP_S  in  2  read response from ROM.
- RLAST_S  in  1  last beat from ROM.
- RVALID_S  in  1  read valid from ROM.
- RREADY_S  out  1  read ready to ROM.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - Samples ARVALID_M0/M1.
  - If exactly one is asserted, grant that master.
  - If both are asserted, grant the master pointed to by the round-robin pointer `prio`; reset value is M0.
  - Grant is registered into `gnt` (1 bit); go to ADDR.
  - With no request, stay in IDLE.
- ADDR
  - ARVALID_S = 1; AR fields are muxed from `gnt`.
  - ARREADY_Mgnt = ARREADY_S; the other master's ARREADY stays 0.
  - On ARVALID_S && ARREADY_S, go to DATA.
- DATA
  - RVALID_Mgnt = RVALID_S and RREADY_S = RREADY_Mgnt. RDATA, RRESP and RLAST pass through.
  - The non-granted master sees RVALID = 0.
  - On RVALID_S && RREADY_S && RLAST_S: go to IDLE and set `prio` = ~gnt.
- `prio` changes only at burst completion. A burst is never pre-empted.
- A master whose ARVALID drops while in ADDR (AXI violation) is not supported. No recovery is required beyond reset.
- R data and RID are returned unmodified except for stripping the tag. RRESP is never generated locally.
- ARBURST is forwarded unchanged; the arbiter does no burst arithmetic.

## Timing
- Reset (async assert, sync deassert)
  - State = IDLE, `gnt` = 0, `prio` = M0.
  - All outputs = 0: ARVALID_S, RREADY_S, ARREADY_Mx, RVALID_Mx, RLAST_Mx, data and ID buses.
- Grant latency:
  - ARVALID_Mx seen in IDLE at edge n, so ARVALID_S is high from cycle n+1.
  - Minimum AR latency is 1 cycle plus ROM ARREADY.
- ARREADY_Mx and all R-side outputs are combinational from the slave inputs in the appropriate state; no extra R latency.
- Back-to-back: after the last beat handshake at edge n, the FSM is in IDLE during cycle n+1 and ADDR in n+2. This gives a one-cycle bubble between bursts.
- Simultaneous new request and last beat: the request is ignored until IDLE; no combinational regrant.
- Single-beat bursts (ARLEN = 0) follow the same path; RLAST_S is asserted on the only beat.
- AR outputs are held stable while ARVALID_S = 1 and ARREADY_S = 0, since the master holds them per AXI.

## Structure
- Shared package `axi_pkg`:
  - state enum {IDLE, ADDR, DATA}.
  - Master tag constants TAG_M0 = 0, TAG_M1 = 1.
  - AR and R field struct typedefs built from the AXI_define widths.
- Optional sub-module `rr_arb2`: 2-input round-robin picker with inputs req[1:0] and prio, output gnt.
- Everything else stays in a single module.

## Test plan
- M0 alone: ARADDR_M0 = 0x100, ARLEN = 3. Expect ARVALID_S one cycle later with ARID_S = {4'h0, ARID_M0}, then 4 beats on M0 with RLAST on the 4th. M1 sees no RVALID.
- M1 alone: ARID_M1 = 4'h5, ARLEN = 0. Expect ARID_S = 8'h15, a single beat routed to M1 with RID_M1 = 5, and ARREADY_M0 = 0 throughout.
- Both masters request at reset: M0 is granted first; after its RLAST handshake, M1 is granted with no further M0 grant in between. Repeat with both held high and check strict alternation over 4 bursts.
- R backpressure: hold RREADY_M0 = 0 for 3 cycles mid-burst. Expect RREADY_S = 0 and data held; the burst completes intact and no beats are lost.
- ARREADY_S delayed 5 cycles: ARVALID_S and the AR fields stay stable, and ARREADY_Mgnt pulses only on the accepting cycle.
- Assert ARESETn low during DATA beat 2: all outputs are 0 immediately. After release, a fresh M1 request completes normally with `prio` back at M0.
